// File: rtl/seq_detector_pkg.sv
// rtl/seq_detector_pkg.sv - shared types and helpers for the serial pattern detector
//
// Purpose: FSM state encoding and width helpers used by seq_detector.
// Ports:   none (package).
package seq_detector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_t;

  // The unused fourth encoding; if the state register ever lands here it
  // falls back to IDLE on the next edge.
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// rtl/seq_detector_sat_counter.sv - saturating up-counter with async active-low clear
//
// Purpose: counts inc pulses and holds at all-ones instead of wrapping.
// Ports:
//   clk   in  1  rising-edge clock
//   clr   in  1  asynchronous active-low clear
//   inc   in  1  add one on this edge (ignored once saturated)
//   count out W  current count
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - programmable N-bit serial pattern detector
//
// Purpose: watches a qualified serial bit stream and flags every occurrence
// of PATTERN (MSB = oldest bit). Reports a one-cycle detect pulse, a sticky
// seen flag cleared by ack, and a saturating hit count.
// Ports:
//   clk    in  1      rising-edge clock
//   clr    in  1      asynchronous active-low reset
//   en     in  1      din is consumed only on edges where en=1
//   din    in  1      serial data bit
//   ack    in  1      clears seen (a simultaneous match wins)
//   detect out 1      registered pulse: pattern completed on the previous edge
//   seen   out 1      sticky match flag
//   hits   out CNT_W  saturating match count
//   state  out 2      FSM state (IDLE=0, FILL=1, ARMED=2)
//   hist   out N      bit history, newest bit in the LSB
// N must be at least 2.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter int           OVERLAP = 1,
  parameter int           CNT_W   = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  input  logic             ack,
  output logic             detect,
  output logic             seen,
  output logic [CNT_W-1:0] hits,
  output logic [1:0]       state,
  output logic [N-1:0]     hist
);

  localparam int            FW   = fill_width(N);
  localparam logic [FW-1:0] FULL = FW'(N);

  logic [FW-1:0] fill;
  logic [FW-1:0] fill_next;
  logic [N-1:0]  hist_next;
  logic          match;

  // fill counts valid bits up to N and then sticks there, so ARMED keeps
  // evaluating every new bit against a full window.
  always_comb begin
    hist_next = {hist[N-2:0], din};
    fill_next = (fill == FULL) ? FULL : fill + 1'b1;
    match     = en && (state != ST_ILLEGAL) && (fill_next == FULL) &&
                (hist_next == PATTERN);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hist   <= '0;
      fill   <= '0;
      state  <= IDLE;
      detect <= 1'b0;
      seen   <= 1'b0;
    end else begin
      detect <= match;

      // Set has priority over ack so a match coinciding with ack is not lost.
      if (match) begin
        seen <= 1'b1;
      end else if (ack) begin
        seen <= 1'b0;
      end

      if (state == ST_ILLEGAL) begin
        state <= IDLE;
        hist  <= '0;
        fill  <= '0;
      end else if (en) begin
        if (match && (OVERLAP == 0)) begin
          // Non-overlapping mode: the next hit must be built from N new bits.
          hist  <= '0;
          fill  <= '0;
          state <= IDLE;
        end else begin
          hist  <= hist_next;
          fill  <= fill_next;
          state <= (fill_next == FULL) ? ARMED : FILL;
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_hits (
    .clk  (clk),
    .clr  (clr),
    .inc  (match),
    .count(hits)
  );

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - self-checking bench for seq_detector (overlap and non-overlap)
module tb_seq_detector;

  localparam int          N   = 4;
  localparam logic [3:0]  PAT = 4'b1011;
  localparam int          MAXH = 15;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic en  = 1'b0;
  logic din = 1'b0;
  logic ack = 1'b0;

  logic       d1_detect, d1_seen;
  logic [3:0] d1_hits, d1_hist;
  logic [1:0] d1_state;
  logic       d0_detect, d0_seen;
  logic [3:0] d0_hits, d0_hist;
  logic [1:0] d0_state;

  seq_detector #(.N(N), .PATTERN(PAT), .OVERLAP(1), .CNT_W(4)) dut1 (
    .clk(clk), .clr(clr), .en(en), .din(din), .ack(ack),
    .detect(d1_detect), .seen(d1_seen), .hits(d1_hits),
    .state(d1_state), .hist(d1_hist)
  );

  seq_detector #(.N(N), .PATTERN(PAT), .OVERLAP(0), .CNT_W(4)) dut0 (
    .clk(clk), .clr(clr), .en(en), .din(din), .ack(ack),
    .detect(d0_detect), .seen(d0_seen), .hits(d0_hits),
    .state(d0_state), .hist(d0_hist)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: the bits received since the last flush (at most N kept), plus
  // the detect/seen/hit bookkeeping. Index 1 = overlapping, 0 = flushing.
  bit q1[$];
  bit q0[$];
  bit m_det[2];
  bit m_seen[2];
  int m_hits[2];
  int pulses[2];

  function automatic int last_n(input bit q[$]);
    int v  = 0;
    int s  = q.size();
    int lo = (s > N) ? s - N : 0;
    for (int i = lo; i < s; i++) v = v * 2 + int'(q[i]);
    return v;
  endfunction

  function automatic int st_of(input int sz);
    if (sz == 0) return 0;
    if (sz < N) return 1;
    return 2;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      q1.delete();
      q0.delete();
      for (int k = 0; k < 2; k++) begin
        m_det[k]  = 1'b0;
        m_seen[k] = 1'b0;
        m_hits[k] = 0;
      end
    end else begin
      m_det[0] = 1'b0;
      m_det[1] = 1'b0;
      if (en) begin
        q1.push_back(din);
        if (q1.size() > N) void'(q1.pop_front());
        q0.push_back(din);
        if (q0.size() > N) void'(q0.pop_front());
        m_det[1] = (q1.size() == N) && (last_n(q1) == int'(PAT));
        m_det[0] = (q0.size() == N) && (last_n(q0) == int'(PAT));
        if (m_det[0]) q0.delete();
      end
      for (int k = 0; k < 2; k++) begin
        if (m_det[k]) begin
          m_seen[k] = 1'b1;
          if (m_hits[k] < MAXH) m_hits[k]++;
        end else if (ack) begin
          m_seen[k] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("d1_detect", int'(d1_detect), int'(m_det[1]));
    chk("d1_seen",   int'(d1_seen),   int'(m_seen[1]));
    chk("d1_hits",   int'(d1_hits),   m_hits[1]);
    chk("d1_hist",   int'(d1_hist),   last_n(q1));
    chk("d1_state",  int'(d1_state),  st_of(q1.size()));
    chk("d0_detect", int'(d0_detect), int'(m_det[0]));
    chk("d0_seen",   int'(d0_seen),   int'(m_seen[0]));
    chk("d0_hits",   int'(d0_hits),   m_hits[0]);
    chk("d0_hist",   int'(d0_hist),   last_n(q0));
    chk("d0_state",  int'(d0_state),  st_of(q0.size()));
    if (d1_detect) pulses[1]++;
    if (d0_detect) pulses[0]++;
  end

  // Inputs change 1 time unit after each rising edge.
  task automatic step(input logic e, input logic d, input logic a);
    en  = e;
    din = d;
    ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    clr = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    clr = 1'b1;
  endtask

  task automatic send4(input logic [3:0] b);
    for (int i = 3; i >= 0; i--) step(1, b[i], 0);
  endtask

  int p1, p0;

  initial begin
    pulses[0] = 0;
    pulses[1] = 0;

    // 1. reset with toggling inputs, then idle after release
    for (int i = 0; i < 4; i++) step(i[0], ~i[1], 0);
    chk("rst_d1_hits", int'(d1_hits), 0);
    chk("rst_d1_state", int'(d1_state), 0);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("idle_d1_state", int'(d1_state), 0);

    // 2. basic match
    send4(4'b1011);
    chk("basic_detect", int'(d1_detect), 1);
    chk("basic_hits",   int'(d1_hits), 1);
    chk("basic_seen",   int'(d1_seen), 1);
    chk("basic_hist",   int'(d1_hist), 11);
    step(0, 0, 0);
    chk("basic_detect_off", int'(d1_detect), 0);

    // 3. overlap vs flush on 1011011
    pulse_reset();
    p1 = pulses[1];
    p0 = pulses[0];
    send4(4'b1011);
    chk("ovl0_state_after", int'(d0_state), 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    chk("ovl1_pulses", pulses[1] - p1, 2);
    chk("ovl0_pulses", pulses[0] - p0, 1);
    chk("ovl1_hits", int'(d1_hits), 2);
    chk("ovl0_hits", int'(d0_hits), 1);

    // 4. en gaps keep a partial match alive
    pulse_reset();
    p1 = pulses[1];
    p0 = pulses[0];
    step(1, 1, 0);
    step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    chk("gap_detect", int'(d1_detect), 1);
    step(0, 0, 0);
    chk("gap_pulses1", pulses[1] - p1, 1);
    chk("gap_pulses0", pulses[0] - p0, 1);
    chk("gap_hits", int'(d1_hits), 1);

    // 5. saturation at 15 and ack priority
    pulse_reset();
    for (int r = 0; r < 16; r++) send4(4'b1011);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    chk("sat_d1_hits", int'(d1_hits), 15);
    chk("sat_d0_hits", int'(d0_hits), 15);
    chk("ack_match_seen1", int'(d1_seen), 1);
    chk("ack_match_seen0", int'(d0_seen), 1);
    step(0, 0, 1);
    chk("ack_clear_seen1", int'(d1_seen), 0);
    chk("ack_clear_seen0", int'(d0_seen), 0);
    chk("ack_keeps_hits", int'(d1_hits), 15);

    // 6. reset mid-pattern loses partial history
    pulse_reset();
    p1 = pulses[1];
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    clr = 1'b0;
    step(0, 0, 0);
    clr = 1'b1;
    step(1, 1, 0);
    chk("midrst_hist", int'(d1_hist), 1);
    chk("midrst_hits", int'(d1_hits), 0);
    step(0, 0, 0);
    chk("midrst_pulses", pulses[1] - p1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
